// File: rtl/pipe_enq_arbiter_if.sv
// Bundle of the two enqueue ports and the single outbound beat pipe
// around pipe_enq_arbiter. The slave modport is the arbiter's view and
// the master modport is the view of whatever drives it.
interface pipe_enq_arbiter_if;
  logic        in0_enq_ena;
  logic [95:0] in0_enq_v;
  logic        in0_enq_rdy;
  logic        in1_enq_ena;
  logic [95:0] in1_enq_v;
  logic        in1_enq_rdy;
  logic        out_enq_ena;
  logic [31:0] out_enq_v;
  logic        out_enq_last;
  logic        out_enq_src;
  logic        out_enq_rdy;

  modport slave (
    input  in0_enq_ena, in0_enq_v, in1_enq_ena, in1_enq_v, out_enq_rdy,
    output in0_enq_rdy, in1_enq_rdy, out_enq_ena, out_enq_v, out_enq_last, out_enq_src
  );

  modport master (
    output in0_enq_ena, in0_enq_v, in1_enq_ena, in1_enq_v, out_enq_rdy,
    input  in0_enq_rdy, in1_enq_rdy, out_enq_ena, out_enq_v, out_enq_last, out_enq_src
  );
endinterface

// File: rtl/pipe_enq_arbiter.sv
// Two-input round-robin arbiter and serializer: each requester parks one
// 96-bit message in its own slot, and granted messages leave as three
// 32-bit beats, low word first, on a shared outbound pipe.
module pipe_enq_arbiter (
  input logic                CLK,
  input logic                nRST,
  pipe_enq_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q;
  logic        sel_q;
  logic [1:0]  beat_q;
  logic        last_grant_q;
  logic [1:0]  full_q;
  logic [1:0]  full_d;
  logic [95:0] slot_q [2];
  logic        send;
  logic        release_slot;
  logic [95:0] cur_msg;
  logic [31:0] cur_word;

  assign send         = (state_q == StSend);
  // Final beat accepted downstream: frees the selected slot at this edge.
  assign release_slot = send && bus.out_enq_rdy && (beat_q == 2'd2);

  // Next full flags: release the sent slot, set on an accepted enqueue.
  always_comb begin
    full_d = full_q;
    if (release_slot) full_d[sel_q] = 1'b0;
    if (bus.in0_enq_ena) full_d[0] = 1'b1;
    if (bus.in1_enq_ena) full_d[1] = 1'b1;
  end

  // Grant/serialize state machine; decisions only see registered full flags.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= StIdle;
      sel_q        <= 1'b0;
      beat_q       <= 2'd0;
      last_grant_q <= 1'b1;
      full_q       <= 2'b00;
    end else begin
      full_q <= full_d;
      case (state_q)
        StIdle: begin
          beat_q <= 2'd0;
          if (full_q == 2'b11) begin
            sel_q   <= ~last_grant_q;
            state_q <= StSend;
          end else if (full_q[0]) begin
            sel_q   <= 1'b0;
            state_q <= StSend;
          end else if (full_q[1]) begin
            sel_q   <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (bus.out_enq_rdy) begin
            if (beat_q == 2'd2) begin
              beat_q       <= 2'd0;
              last_grant_q <= sel_q;
              state_q      <= StIdle;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Message slots; contents are don't-care while empty, so no reset.
  always_ff @(posedge CLK) begin
    if (bus.in0_enq_ena) slot_q[0] <= bus.in0_enq_v;
    if (bus.in1_enq_ena) slot_q[1] <= bus.in1_enq_v;
  end

  // Pick the current beat out of the selected slot.
  always_comb begin
    cur_msg = slot_q[sel_q];
    case (beat_q)
      2'd0:    cur_word = cur_msg[31:0];
      2'd1:    cur_word = cur_msg[63:32];
      default: cur_word = cur_msg[95:64];
    endcase
  end

  // Port outputs, derived only from registered state and nRST/out RDY.
  always_comb begin
    bus.in0_enq_rdy  = nRST & ~full_q[0];
    bus.in1_enq_rdy  = nRST & ~full_q[1];
    bus.out_enq_ena  = nRST & send & bus.out_enq_rdy;
    bus.out_enq_v    = send ? cur_word : 32'd0;
    bus.out_enq_last = send & (beat_q == 2'd2);
    bus.out_enq_src  = send & sel_q;
  end

endmodule

// File: tb/tb_pipe_enq_arbiter.sv
// Randomized bench for pipe_enq_arbiter against a transaction-level model:
// a granted message becomes a queue of expected beats that is popped as
// the downstream accepts them.
module tb_pipe_enq_arbiter;

  typedef struct packed {
    logic [31:0] w;
    logic        last;
    logic        src;
  } beat_t;

  logic clk;
  logic rst_n;
  pipe_enq_arbiter_if bus ();

  pipe_enq_arbiter dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state.
  bit          m_full [2];
  logic [95:0] m_slot [2];
  bit          m_lg;
  beat_t       exp_q [$];

  // Observation logs, cleared per phase.
  int xfer_cyc [$];
  int done_cyc [$];
  int done_src [$];

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [95:0] rnd_msg();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clear_logs();
    xfer_cyc.delete();
    done_cyc.delete();
    done_src.delete();
  endtask

  // One clock cycle: drive, check outputs against the model, step the model.
  task automatic cycle(input bit e0_req, input bit e1_req, input logic [95:0] d0,
                       input logic [95:0] d1, input bit ordy, input bit rst);
    bit    e0, e1, busy;
    int    g;
    beat_t b;
    e0 = e0_req && rst && !m_full[0];
    e1 = e1_req && rst && !m_full[1];
    rst_n           = rst;
    bus.in0_enq_ena = e0;
    bus.in0_enq_v   = d0;
    bus.in1_enq_ena = e1;
    bus.in1_enq_v   = d1;
    bus.out_enq_rdy = ordy;
    #1;
    busy = (exp_q.size() != 0);
    check_eq("in0_rdy", 96'(bus.in0_enq_rdy), 96'(rst && !m_full[0]));
    check_eq("in1_rdy", 96'(bus.in1_enq_rdy), 96'(rst && !m_full[1]));
    check_eq("out_ena", 96'(bus.out_enq_ena), 96'(rst && busy && ordy));
    if (rst) begin
      if (busy) begin
        check_eq("out_v", 96'(bus.out_enq_v), 96'(exp_q[0].w));
        check_eq("out_last", 96'(bus.out_enq_last), 96'(exp_q[0].last));
        check_eq("out_src", 96'(bus.out_enq_src), 96'(exp_q[0].src));
      end else begin
        check_eq("idle_last", 96'(bus.out_enq_last), 96'd0);
        check_eq("idle_src", 96'(bus.out_enq_src), 96'd0);
      end
    end
    @(posedge clk);
    if (!rst) begin
      m_full[0] = 1'b0;
      m_full[1] = 1'b0;
      m_lg      = 1'b1;
      exp_q.delete();
    end else begin
      if (busy) begin
        if (ordy) begin
          b = exp_q.pop_front();
          xfer_cyc.push_back(cyc);
          if (b.last) begin
            m_full[b.src] = 1'b0;
            m_lg          = b.src;
            done_cyc.push_back(cyc);
            done_src.push_back(int'(b.src));
          end
        end
      end else begin
        g = -1;
        if (m_full[0] && m_full[1]) g = m_lg ? 0 : 1;
        else if (m_full[0])         g = 0;
        else if (m_full[1])         g = 1;
        if (g >= 0) begin
          for (int i = 0; i < 3; i++) begin
            b.w    = m_slot[g][32*i +: 32];
            b.last = (i == 2);
            b.src  = (g == 1);
            exp_q.push_back(b);
          end
        end
      end
      if (e0) begin m_full[0] = 1'b1; m_slot[0] = d0; end
      if (e1) begin m_full[1] = 1'b1; m_slot[1] = d1; end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 96'd0, 96'd0, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 96'd0, 96'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 96'd0, 96'd0, 1'b1, 1'b0);
  endtask

  initial begin
    int t;
    int guard;
    m_lg = 1'b1;

    // Reset state.
    do_reset();
    idle(2);

    // Single message with fixed latency.
    clear_logs();
    t = cyc;
    cycle(1'b1, 1'b0, {32'h33333333, 32'h22222222, 32'h00000001}, 96'd0, 1'b1, 1'b1);
    idle(6);
    check_eq("single_xfers", 96'(xfer_cyc.size()), 96'd3);
    for (int i = 0; i < xfer_cyc.size() && i < 3; i++)
      check_eq("single_beat_cyc", 96'(xfer_cyc[i]), 96'(t + 2 + i));

    // Tie after reset: requester 0 first, then 1 after one idle cycle.
    do_reset();
    clear_logs();
    cycle(1'b1, 1'b1, rnd_msg(), rnd_msg(), 1'b1, 1'b1);
    idle(10);
    check_eq("tie_count", 96'(done_src.size()), 96'd2);
    if (done_src.size() == 2) begin
      check_eq("tie_first", 96'(done_src[0]), 96'd0);
      check_eq("tie_second", 96'(done_src[1]), 96'd1);
      check_eq("tie_gap", 96'(done_cyc[1] - done_cyc[0]), 96'd4);
    end

    // Round-robin under saturation.
    do_reset();
    clear_logs();
    guard = 0;
    while (done_src.size() < 8 && guard < 200) begin
      cycle(1'b1, 1'b1, rnd_msg(), rnd_msg(), 1'b1, 1'b1);
      guard++;
    end
    check_eq("rr_count", 96'(done_src.size() >= 8), 96'd1);
    for (int i = 0; i < done_src.size() && i < 8; i++) begin
      check_eq("rr_src", 96'(done_src[i]), 96'(i % 2));
      if (i > 0) check_eq("rr_gap", 96'(done_cyc[i] - done_cyc[i-1]), 96'd4);
    end
    idle(12);

    // Backpressure for 3 cycles on beat 1.
    clear_logs();
    t = cyc;
    cycle(1'b1, 1'b0, rnd_msg(), 96'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 96'd0, 96'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 96'd0, 96'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 96'd0, 96'd0, 1'b0, 1'b1);
    idle(4);
    check_eq("bp_xfers", 96'(xfer_cyc.size()), 96'd3);
    check_eq("bp_done_cyc", 96'(done_cyc.size() > 0 ? done_cyc[0] : -1), 96'(t + 7));

    // Load during send: in1 enqueues on in0's beat 1.
    clear_logs();
    t = cyc;
    cycle(1'b1, 1'b0, rnd_msg(), 96'd0, 1'b1, 1'b1);
    idle(2);
    cycle(1'b0, 1'b1, 96'd0, rnd_msg(), 1'b1, 1'b1);
    idle(8);
    check_eq("lds_count", 96'(done_src.size()), 96'd2);
    if (done_src.size() == 2) begin
      check_eq("lds_src", 96'(done_src[1]), 96'd1);
      check_eq("lds_done_cyc", 96'(done_cyc[1]), 96'(t + 8));
    end

    // Reset right after beat 0.
    clear_logs();
    cycle(1'b1, 1'b1, rnd_msg(), rnd_msg(), 1'b1, 1'b1);
    idle(2);
    cycle(1'b0, 1'b0, 96'd0, 96'd0, 1'b1, 1'b0);
    idle(6);
    check_eq("rst_xfers", 96'(xfer_cyc.size()), 96'd1);
    clear_logs();
    cycle(1'b0, 1'b1, 96'd0, rnd_msg(), 1'b1, 1'b1);
    idle(6);
    check_eq("post_rst_xfers", 96'(xfer_cyc.size()), 96'd3);
    check_eq("post_rst_src", 96'(done_src.size() > 0 ? done_src[0] : -1), 96'd1);

    // Random traffic with backpressure and occasional reset.
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_msg(), rnd_msg(),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) != 0));
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
